// File: rtl/conveyor_pkg.sv
// Shared conveyor definitions: sensor FSM states and default timing constants.
// Also used by the downstream product/carton counter stage.
package conveyor_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_JAM_CYCLES      = 50000;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    JAM
  } sensor_state_t;

endpackage

// File: rtl/product_sensor_cond_if.sv
// Signal bundle between the conveyor controller and the sensor conditioner.
// master drives the raw sensor and controls; slave is the conditioner.
interface product_sensor_cond_if;

  logic sensor_in;
  logic enable;
  logic jam_clear;
  logic product_pulse;
  logic sensor_stable;
  logic jam;

  modport master (
    output sensor_in,
    output enable,
    output jam_clear,
    input  product_pulse,
    input  sensor_stable,
    input  jam
  );

  modport slave (
    input  sensor_in,
    input  enable,
    input  jam_clear,
    output product_pulse,
    output sensor_stable,
    output jam
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter. 'stable' is the
// accepted level; 'stable_next' is its next-state value, so a consumer can
// register an event in the same cycle that 'stable' changes.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_in,
  output logic stable,
  output logic stable_next
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta;
  logic          sync;
  logic          stable_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Synchroniser: no logic ahead of the second flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= sensor_in;
      sync      <= sync_meta;
    end
  end

  // Count cycles of disagreement; accept the new level on the last one.
  always_comb begin
    count_d     = '0;
    stable_next = stable_q;
    if (sync != stable_q) begin
      if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_next = ~stable_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      stable_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      stable_q <= stable_next;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/product_sensor_cond.sv
// Conveyor photo-sensor conditioner: one product_pulse per accepted arrival,
// debounced sensor level and optional sticky jam detection.
// Jam detection is built only when PRODUCT_SENSOR_JAM_DETECT_EN is defined.
module product_sensor_cond
  import conveyor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned JAM_CYCLES      = DEFAULT_JAM_CYCLES
) (
  input logic                 clock,
  input logic                 reset,
  product_sensor_cond_if.slave bus
);

  logic          stable_q;
  logic          stable_next;
  sensor_state_t state_q;
  sensor_state_t state_d;
  logic          pulse_q;
  logic          pulse_d;
  logic          jam_q;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clock      (clock),
    .reset      (reset),
    .sensor_in  (bus.sensor_in),
    .stable     (stable_q),
    .stable_next(stable_next)
  );

`ifdef PRODUCT_SENSOR_JAM_DETECT_EN
  localparam int unsigned TW = $clog2(JAM_CYCLES + 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [TW-1:0] timer_inc;

  // Next state: pulse only on a fresh arrival; jam latches until cleared while clear.
  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    timer_d   = '0;
    timer_inc = (timer_q == TW'(JAM_CYCLES)) ? timer_q : timer_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (stable_next) begin
          state_d = PRESENT;
          pulse_d = bus.enable;
        end
      end
      PRESENT: begin
        if (!stable_next) begin
          state_d = IDLE;
        end else if (timer_inc == TW'(JAM_CYCLES)) begin
          state_d = JAM;
        end else begin
          timer_d = timer_inc;
        end
      end
      JAM: begin
        if (bus.jam_clear && !stable_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Jam timer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_jam_clear;
  localparam int unsigned unused_jam_cycles = JAM_CYCLES;

  assign unused_jam_clear = bus.jam_clear;

  // Next state: IDLE/PRESENT only, unlimited dwell while blocked.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable_next) begin
          state_d = PRESENT;
          pulse_d = bus.enable;
        end
      end
      PRESENT: begin
        if (!stable_next) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      jam_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      jam_q   <= (state_d == JAM);
    end
  end

  assign bus.product_pulse = pulse_q;
  assign bus.sensor_stable = stable_q;
  assign bus.jam           = jam_q;

endmodule

// File: tb/tb_product_sensor_cond.sv
// Directed bench for product_sensor_cond with DEBOUNCE_CYCLES=4, JAM_CYCLES=20.
// Jam scenarios are selected by PRODUCT_SENSOR_JAM_DETECT_EN.
module tb_product_sensor_cond;

  localparam int unsigned DEB = 4;
  localparam int unsigned JAMC = 20;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  int   base;

  product_sensor_cond_if bus ();

  product_sensor_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .JAM_CYCLES     (JAMC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Pulse counter sampled away from the active edge.
  always @(negedge clock) begin
    if (bus.product_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic p, input logic s, input logic j);
    chk({tag, "_pulse"}, bus.product_pulse, p);
    chk({tag, "_stable"}, bus.sensor_stable, s);
    chk({tag, "_jam"}, bus.jam, j);
  endtask

  initial begin
    reset         = 1'b1;
    bus.sensor_in = 1'b0;
    bus.enable    = 1'b1;
    bus.jam_clear = 1'b0;
    #1;
    outs("reset", 1'b0, 1'b0, 1'b0);
    step(2);
    reset = 1'b0;
    step(3);
    outs("idle", 1'b0, 1'b0, 1'b0);

    // 1. Clean product: 10 cycles high.
    base = pulse_cnt;
    bus.sensor_in = 1'b1;
    step(5);
    outs("clean_pre", 1'b0, 1'b0, 1'b0);
    step(1);
    outs("clean_rise", 1'b1, 1'b1, 1'b0);
    step(1);
    outs("clean_after", 1'b0, 1'b1, 1'b0);
    step(3);
    bus.sensor_in = 1'b0;
    step(5);
    chk("clean_hold", bus.sensor_stable, 1'b1);
    step(1);
    outs("clean_fall", 1'b0, 1'b0, 1'b0);
    step(2);
    chk_int("clean_count", pulse_cnt - base, 1);

    // 2. Glitch rejection, then chatter followed by solid high.
    base = pulse_cnt;
    bus.sensor_in = 1'b1;
    step(3);
    bus.sensor_in = 1'b0;
    step(10);
    outs("glitch", 1'b0, 1'b0, 1'b0);
    chk_int("glitch_count", pulse_cnt - base, 0);
    bus.sensor_in = 1'b1;
    step(1);
    bus.sensor_in = 1'b0;
    step(1);
    bus.sensor_in = 1'b1;
    step(5);
    chk("chatter_pre", bus.sensor_stable, 1'b0);
    step(1);
    outs("chatter_rise", 1'b1, 1'b1, 1'b0);
    step(1);
    bus.sensor_in = 1'b0;
    step(8);
    chk("chatter_fall", bus.sensor_stable, 1'b0);
    chk_int("chatter_count", pulse_cnt - base, 1);

    // 3. Enable gating: arrival with enable low is lost, not deferred.
    base = pulse_cnt;
    bus.enable = 1'b0;
    bus.sensor_in = 1'b1;
    step(6);
    outs("en_off_rise", 1'b0, 1'b1, 1'b0);
    step(2);
    bus.enable = 1'b1;
    step(4);
    outs("en_raised", 1'b0, 1'b1, 1'b0);
    bus.sensor_in = 1'b0;
    step(8);
    chk("en_fall", bus.sensor_stable, 1'b0);
    chk_int("en_off_count", pulse_cnt - base, 0);
    base = pulse_cnt;
    bus.sensor_in = 1'b1;
    step(6);
    outs("en_on_rise", 1'b1, 1'b1, 1'b0);
    step(1);
    bus.sensor_in = 1'b0;
    step(8);
    chk_int("en_on_count", pulse_cnt - base, 1);

`ifdef PRODUCT_SENSOR_JAM_DETECT_EN
    // 4. Jam: sensor blocked; clear ignored while blocked, honoured once clear.
    base = pulse_cnt;
    bus.sensor_in = 1'b1;
    step(6);
    outs("jam_rise", 1'b1, 1'b1, 1'b0);
    step(19);
    chk("jam_pre", bus.jam, 1'b0);
    step(1);
    outs("jam_set", 1'b0, 1'b1, 1'b1);
    step(4);
    bus.jam_clear = 1'b1;
    step(1);
    bus.jam_clear = 1'b0;
    chk("jam_clr_ignored", bus.jam, 1'b1);
    bus.sensor_in = 1'b0;
    step(6);
    outs("jam_low", 1'b0, 1'b0, 1'b1);
    step(1);
    chk("jam_not_remembered", bus.jam, 1'b1);
    bus.jam_clear = 1'b1;
    step(1);
    bus.jam_clear = 1'b0;
    outs("jam_cleared", 1'b0, 1'b0, 1'b0);
    bus.sensor_in = 1'b1;
    step(6);
    outs("post_clear_rise", 1'b1, 1'b1, 1'b0);
    chk_int("jam_count", pulse_cnt - base, 2);
    step(20);
    chk("jam_again", bus.jam, 1'b1);
`else
    // 4. Without jam detection a long block is one product and never jams.
    base = pulse_cnt;
    bus.sensor_in = 1'b1;
    step(6);
    outs("block_rise", 1'b1, 1'b1, 1'b0);
    step(24);
    outs("block_hold", 1'b0, 1'b1, 1'b0);
    chk_int("block_count", pulse_cnt - base, 1);
`endif

    // 5. Reset mid-operation with the sensor still high.
    base = pulse_cnt;
    reset = 1'b1;
    #1;
    outs("rst_mid", 1'b0, 1'b0, 1'b0);
    step(2);
    outs("rst_hold", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(5);
    chk("rst_pre", bus.sensor_stable, 1'b0);
    step(1);
    outs("rst_rearrive", 1'b1, 1'b1, 1'b0);
    step(1);
    bus.sensor_in = 1'b0;
    step(8);
    outs("rst_fall", 1'b0, 1'b0, 1'b0);
    chk_int("rst_count", pulse_cnt - base, 1);

    // 6. Back-to-back products, 5 high / 5 low.
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.sensor_in = 1'b1;
      step(5);
      bus.sensor_in = 1'b0;
      step(5);
    end
    step(8);
    outs("b2b_end", 1'b0, 1'b0, 1'b0);
    chk_int("b2b_count", pulse_cnt - base, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_sensor_cond.md
# product_sensor_cond

Conditions the raw photo-sensor on the conveyor and produces one clean single-cycle `product_pulse` per product passing the sensor. Sits directly upstream of the product/carton counter-and-display stage, which counts these pulses instead of free-running on the clock. Provides synchronisation, debounce, a registered stable level and sticky jam detection for a sensor blocked too long.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a new synchronised level must hold before it is accepted; legal range ≥1.
- JAM_CYCLES, 50000: consecutive cycles of stable-high (sensor blocked) that declare a jam; must be > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- sensor_in  in  1  raw sensor, asynchronous to clock; 1 = object present.
- enable  in  1  1 = pulses allowed; 0 = pulses suppressed, conditioning continues.
- jam_clear  in  1  single-cycle request to clear a latched jam.
- product_pulse  out  1  one-cycle pulse per accepted product arrival.
- sensor_stable  out  1  debounced sensor level.
- jam  out  1  sticky jam flag.

## Operation
- Two-flop synchroniser on sensor_in, giving `sync`; no logic before the second flop.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1), clears whenever `sync == sensor_stable`. It increments each cycle they differ. When it would reach DEBOUNCE_CYCLES, sensor_stable toggles and the counter clears.
- FSM states:
  - IDLE: stable 0.
  - PRESENT: stable 1, jam timer running.
  - JAM: stable 1 or 0, jam latched.
- FSM transitions:
  - IDLE→PRESENT on stable rising.
  - PRESENT→IDLE on stable falling.
  - PRESENT→JAM when the jam timer reaches JAM_CYCLES.
  - JAM→IDLE only when jam_clear=1 and sensor_stable=0 in the same cycle. jam_clear with stable=1 is ignored, not remembered.
- product_pulse=1 for exactly one cycle on the IDLE→PRESENT transition, and only if enable=1 in that cycle. Never asserted in JAM.
- Jam timer, width $clog2(JAM_CYCLES+1), counts only in PRESENT and saturates. It clears on entry to PRESENT and in every other state.
- jam=1 exactly while the FSM is in JAM.
- Glitches shorter than DEBOUNCE_CYCLES cycles, measured at `sync`, produce no change on any output.
- enable toggling mid-product never creates or splits a pulse. An arrival seen with enable=0 is lost, not deferred.

## Timing
- Reset values: product_pulse=0, sensor_stable=0, jam=0, FSM=IDLE, all counters 0, synchroniser flops 0.
- All outputs are registered; no combinational path from input to output.
- Latency: raw edge held steady → sensor_stable changes 2+DEBOUNCE_CYCLES rising edges later (±1 for sampling uncertainty). product_pulse rises in the same cycle as sensor_stable.
- Jam: jam rises JAM_CYCLES cycles after sensor_stable rose, if the sensor stays blocked.
- Clear: jam falls one cycle after a qualifying jam_clear.
- Minimum spacing between two product_pulses is 2×DEBOUNCE_CYCLES cycles, because a low phase must be debounced between products.
- Reset asserted mid-debounce or in JAM: immediate return to the reset state.
  - After release, a sensor already high yields one pulse after the full debounce, treated as a new arrival.

## Configuration
- Macro PRODUCT_SENSOR_JAM_DETECT_EN.
- Defined: jam timer, JAM state, jam output and jam_clear are active as described.
- Not defined:
  - The timer and JAM state are not built.
  - jam is tied 0 and jam_clear is ignored.
  - The FSM reduces to IDLE/PRESENT with unlimited dwell.

## Structure
- Shared package `conveyor_pkg`: FSM state enum `sensor_state_t` (IDLE, PRESENT, JAM) and default constants for DEBOUNCE_CYCLES and JAM_CYCLES. The downstream counter stage also uses the package.
- One sub-module, `sync_debounce`: synchroniser plus debounce counter, outputting the stable level. The top holds the FSM, jam timer and pulse generation.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, JAM_CYCLES=20, macro defined.
1. Clean product: sensor_in 0→1 held 10 cycles, then 0 → one product_pulse about 6 cycles after the rise; sensor_stable high for about 10 cycles; jam stays 0.
2. Glitch rejection: sensor_in high 3 cycles then low → no pulse, sensor_stable stays 0. Chatter 1-0-1 at 1-cycle spacing, then solid high → exactly one pulse.
3. Enable gating: enable=0 through a product arrival → no pulse. enable raised while still PRESENT → still no pulse. Next product with enable=1 → one pulse.
4. Jam: sensor held high 30 cycles → jam=1 about 20 cycles after sensor_stable rose.
   - jam_clear while still high → ignored.
   - Sensor low, then jam_clear → jam=0 next cycle, and the next product pulses.
5. Reset mid-operation: reset pulsed while in JAM with the sensor high → all outputs 0 immediately. After release, one pulse after about 6 cycles.
6. Back-to-back: 5 products each 5 high / 5 low cycles → exactly 5 pulses. Repeat with the macro undefined and a 30-cycle block → one pulse, jam stays 0.
